// File: rtl/io_mailbox.sv
// io_mailbox: memory-mapped 16-bit word FIFO mailbox slave with a status register,
// an interrupt threshold register and programmable wait-state insertion.
module io_mailbox #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] Address,
  inout  wire  [15:0] Data,
  input  logic        nME,
  input  logic        nOE,
  input  logic        RnW,
  input  logic        ALE,
  input  logic        nSel,
  output wire         nWait,
  output wire         nIRQ
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_waitCnt;
  logic [15:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_wp;
  logic [PW-1:0]  r_rp;
  logic [7:0]     r_count;
  logic           r_ovf;
  logic           r_unf;
  logic [7:0]     r_thresh;
  logic           r_irqEn;
  logic           r_rdData;

  logic           w_sel;
  logic           w_full;
  logic           w_empty;
  logic           w_enterActive;
  logic           w_commit;
  logic           w_endAccess;
  logic           w_push;
  logic           w_waitLow;
  logic           w_drive;
  logic           w_irq;
  logic [15:0]    w_rdata;
  logic           w_unused;

  assign w_sel    = !nSel && !nME;
  assign w_full   = (r_count == 8'(DEPTH));
  assign w_empty  = (r_count == 8'd0);
  assign w_unused = ^{ALE, Address[15:2]};

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_waitLow = 1'b0;
    w_drive   = 1'b0;
    case (r_state)
      IDLE:    if (w_sel) w_next = (WAIT_STATES > 0) ? WAIT : ACTIVE;
      WAIT: begin
        w_waitLow = 1'b1;
        if (r_waitCnt == 8'd1) w_next = ACTIVE;
      end
      ACTIVE: begin
        w_drive = w_sel && RnW && !nOE;
        if (!w_sel) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A write commits only on the single edge that moves the access into ACTIVE.
  assign w_enterActive = (w_next == ACTIVE) && (r_state != ACTIVE);
  assign w_commit      = w_enterActive && w_sel && !RnW;
  assign w_endAccess   = (r_state == ACTIVE) && !w_sel;
  assign w_push        = w_commit && (Address[1:0] == 2'd0) && !w_full;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)                    r_waitCnt <= 8'd0;
    else if (r_state == IDLE && w_sel) r_waitCnt <= 8'(WAIT_STATES);
    else if (r_state == WAIT)       r_waitCnt <= r_waitCnt - 8'd1;
  end

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wp] <= Data;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= 8'd0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_thresh <= 8'd0;
      r_irqEn  <= 1'b0;
      r_rdData <= 1'b0;
    end else begin
      if (w_enterActive) r_rdData <= w_sel && RnW && (Address[1:0] == 2'd0);
      if (w_commit) begin
        case (Address[1:0])
          2'd0: if (w_full) r_ovf <= 1'b1;
          2'd1: begin
            if (Data[2]) r_ovf <= 1'b0;
            if (Data[3]) r_unf <= 1'b0;
          end
          2'd2: begin
            r_thresh <= Data[15:8];
            r_irqEn  <= Data[0];
          end
          default: ;
        endcase
      end
      if (w_push) begin
        r_wp    <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
        r_count <= r_count + 8'd1;
      end
      // The head is consumed only when the DATA read access finishes.
      if (w_endAccess && r_rdData) begin
        if (w_empty) r_unf <= 1'b1;
        else begin
          r_rp    <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
          r_count <= r_count - 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_rdata = 16'h0000;
    case (Address[1:0])
      2'd0:    if (!w_empty) w_rdata = r_mem[r_rp];
      2'd1:    w_rdata = {r_count, 4'b0000, r_unf, r_ovf, w_full, w_empty};
      2'd2:    w_rdata = {r_thresh, 7'b0000000, r_irqEn};
      default: w_rdata = 16'h0000;
    endcase
  end

  assign w_irq = r_irqEn && (r_thresh != 8'd0) && (r_count >= r_thresh);

  assign Data  = w_drive ? w_rdata : 16'hzzzz;
  assign nWait = w_waitLow ? 1'b0 : 1'bz;
  assign nIRQ  = w_irq ? 1'b0 : 1'bz;

endmodule

// File: doc/io_mailbox.md
Name: io_mailbox

Overview:
- Memory-mapped bus slave (responder) on the demultiplexed system bus, alongside ram, io_leds, io_switches, io_timer and io_serial.
- Gives the cpu a 16-bit word FIFO mailbox. The FIFO has a status register, an interrupt control register and programmable wait-state insertion.
- Selected by the system decoder through its own nSel line. Drives the shared open-drain nWait and nIRQ lines.

Parameters:
- DEPTH, 16, FIFO depth in 16-bit words; legal range 2..255.
- WAIT_STATES, 1, number of cycles nWait is held low at the start of every selected access; 0 means no wait.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- nReset  input  1  asynchronous active-low reset.
- Address  input  16  bus address; only Address[1:0] is decoded.
- Data  inout  16  bus data; driven only during a selected read, otherwise high-Z.
- nME  input  1  memory enable, active low; marks the access window.
- nOE  input  1  output enable, active low.
- RnW  input  1  1 = read, 0 = write.
- ALE  input  1  address latch enable; ignored, because Address is already demultiplexed.
- nSel  input  1  chip select from the decoder, active low.
- nWait  output  1  open-drain: drives 0 or high-Z; the bus pull-up supplies 1.
- nIRQ  output  1  open-drain: drives 0 or high-Z.

Behaviour:
- Clock is the single clock. nReset is asynchronous and active low.
- Reset clears the FIFO (count=0, pointers=0), the sticky flags, IRQ_EN and THRESH, and sets the FSM to IDLE. Data, nWait and nIRQ go high-Z immediately, without waiting for a clock edge. Asserting reset during an access aborts it with no commit.
- Register map, Address[1:0]:
  - 0 DATA: write pushes the word; read returns the FIFO head and pops it at access end.
  - 1 STATUS: read returns [15:8]=count, [3]=underflow, [2]=overflow, [1]=full, [0]=empty, all other bits 0. Writing a 1 to bit 2 or bit 3 clears that flag.
  - 2 CTRL: read/write; [15:8]=THRESH, [0]=IRQ_EN, other bits read 0.
  - 3: reads 0; writes are ignored.
- Selected access: nSel=0 and nME=0, sampled on a rising edge.
- FSM states: IDLE, WAIT, ACTIVE, DONE.
  - IDLE -> WAIT on a selected access when WAIT_STATES>0; IDLE -> ACTIVE when WAIT_STATES=0.
  - WAIT: nWait driven 0 combinationally from entry; a down-counter loaded with WAIT_STATES decrements each cycle. WAIT -> ACTIVE on the edge where the counter reaches 0, and nWait releases at that edge. nWait is therefore low for exactly WAIT_STATES cycles.
  - Entering ACTIVE: a write (RnW=0) commits on that edge, exactly once per access.
  - ACTIVE -> DONE on the first edge with nME=1 or nSel=1. On that edge a DATA read pops the FIFO if it is non-empty. DONE -> IDLE on the next edge.
  - A new access is therefore not recognised on the edge that ends the previous one.
- Read data: Data = mux(Address[1:0]) whenever state is ACTIVE and nSel=0, nME=0, RnW=1, nOE=0; otherwise Data is high-Z. Reading an empty DATA register returns 16'h0000, sets underflow and does not pop.
- Push while full: the word is dropped, overflow is set and count is unchanged.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0). Push and pop cannot occur in the same cycle because the bus is single-master.
- nIRQ: driven 0 when IRQ_EN=1, THRESH!=0 and count>=THRESH; otherwise high-Z. It is evaluated from registered state, so it updates the cycle after a push or pop.
- An access with nSel high is ignored entirely: nWait and Data stay high-Z.

Test Plan:
- Reset: hold nReset=0 during an ACTIVE read, then release → Data and nWait high-Z immediately; STATUS reads 16'h0001.
- Push and pop: write 16'hA5A5 then 16'h1234 to DATA; STATUS reads 16'h0200 → DATA reads return A5A5 then 1234; STATUS then reads 16'h0001.
- Overflow and wrap: write DEPTH+1 words 0..16 → STATUS = 16'h1006; reading 16 words returns 0..15 in order; write 16'h0004 to STATUS → overflow cleared.
- Underflow: read DATA while empty → 16'h0000 returned, STATUS bit3=1, count stays 0.
- IRQ threshold: CTRL=16'h0301, push 2 words → nIRQ high-Z; push a 3rd → nIRQ=0 from the next cycle; pop 1 → nIRQ high-Z.
- Wait states: WAIT_STATES=3, selected write → nWait low for exactly 3 cycles and the write commits once; the same access with nSel=1 → no nWait, no commit.
